// File: rtl/pwm_drive_sequencer_if.sv
// Command handshake between a motion controller and the drive sequencer.
// The controller offers a signed command; the sequencer accepts it when both valid and ready are high.
interface pwm_drive_sequencer_if;
  logic               cmd_valid;
  logic signed [15:0] cmd;
  logic               cmd_ready;

  modport master (output cmd_valid, output cmd, input cmd_ready);
  modport slave  (input cmd_valid, input cmd, output cmd_ready);
endinterface

// File: rtl/pwm_drive_sequencer.sv
// Slew-limited, dead-time-protected drive command sequencer for a bidirectional PWM stage.
// Ramps drive_cmd toward a clamped target, passes through zero on reversals, and latches power-stage faults.
module pwm_drive_sequencer #(
  parameter int MAX_MAG      = 4000,
  parameter int RAMP_STEP    = 40,
  parameter int RAMP_DIV     = 100,
  parameter int DEADTIME_CYC = 10000
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enable,
  pwm_drive_sequencer_if.slave   cmd_bus,
  input  logic                   fault_in,
  input  logic                   fault_clr,
  output logic signed [15:0]     drive_cmd,
  output logic [1:0]             state,
  output logic                   at_target
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DWELL = 2'd2,
    ST_FAULT = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    DIR_NONE = 2'd0,
    DIR_POS  = 2'd1,
    DIR_NEG  = 2'd2
  } dir_t;

  localparam logic signed [16:0] MAG_POS    = 17'(MAX_MAG);
  localparam logic signed [16:0] MAG_NEG    = -17'(MAX_MAG);
  localparam logic signed [16:0] STEP_S     = 17'(RAMP_STEP);
  localparam logic [15:0]        TICK_LAST  = 16'(RAMP_DIV - 1);
  localparam logic [19:0]        DWELL_LOAD = 20'(DEADTIME_CYC);

  state_t             state_reg, state_next;
  dir_t               last_dir_reg, last_dir_next;
  logic signed [15:0] drive_reg, drive_next;
  logic signed [15:0] target_reg, target_next;
  logic [15:0]        tick_reg, tick_next;
  logic [19:0]        dwell_reg, dwell_next;
  logic               cmd_ready_reg, cmd_ready_next;
  logic               at_target_reg, at_target_next;

  logic               accept;
  logic               tick;
  logic signed [16:0] cmd_ext;
  logic signed [15:0] cmd_clamped;
  logic signed [15:0] eff_target;
  logic signed [15:0] eff_target_next;
  logic               eff_pos, eff_neg;
  logic               drv_pos, drv_neg;
  logic signed [15:0] waypoint;
  logic signed [16:0] drv_ext;
  logic signed [16:0] diff;
  logic signed [16:0] abs_diff;
  logic signed [16:0] step;
  logic signed [15:0] ramped;
  logic               reversal;

  assign accept  = cmd_bus.cmd_valid & cmd_ready_reg;
  assign tick    = (tick_reg == TICK_LAST);
  assign cmd_ext = {cmd_bus.cmd[15], cmd_bus.cmd};

  always_comb begin
    if (cmd_ext > MAG_POS)
      cmd_clamped = 16'(MAG_POS);
    else if (cmd_ext < MAG_NEG)
      cmd_clamped = 16'(MAG_NEG);
    else
      cmd_clamped = cmd_bus.cmd;
  end

  assign eff_target = enable ? target_reg : 16'sd0;
  assign eff_pos    = !eff_target[15] && (eff_target != 16'sd0);
  assign eff_neg    = eff_target[15];
  assign drv_pos    = !drive_reg[15] && (drive_reg != 16'sd0);
  assign drv_neg    = drive_reg[15];

  // An opposing target must first bring the drive back to zero before a dwell can start.
  assign waypoint = ((drv_pos && eff_neg) || (drv_neg && eff_pos)) ? 16'sd0 : eff_target;

  assign drv_ext  = {drive_reg[15], drive_reg};
  assign diff     = {waypoint[15], waypoint} - drv_ext;
  assign abs_diff = diff[16] ? -diff : diff;
  assign step     = (abs_diff > STEP_S) ? STEP_S : abs_diff;
  assign ramped   = 16'(diff[16] ? (drv_ext - step) : (drv_ext + step));

  assign reversal = ((last_dir_reg == DIR_POS) && eff_neg) ||
                    ((last_dir_reg == DIR_NEG) && eff_pos);

  always_comb begin
    state_next    = state_reg;
    drive_next    = drive_reg;
    target_next   = accept ? cmd_clamped : target_reg;
    last_dir_next = last_dir_reg;
    tick_next     = tick ? 16'd0 : 16'(tick_reg + 16'd1);
    dwell_next    = dwell_reg;

    if (drv_pos)
      last_dir_next = DIR_POS;
    else if (drv_neg)
      last_dir_next = DIR_NEG;

    if (fault_in) begin
      state_next = ST_FAULT;
      drive_next = 16'sd0;
      tick_next  = 16'd0;
      dwell_next = 20'd0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (eff_target != 16'sd0)
            state_next = ST_RUN;
        end
        ST_RUN: begin
          if (drive_reg == 16'sd0 && eff_target == 16'sd0) begin
            state_next    = ST_IDLE;
            last_dir_next = DIR_NONE;
          end else if (drive_reg == 16'sd0 && reversal) begin
            state_next = ST_DWELL;
            dwell_next = DWELL_LOAD;
          end else if (tick) begin
            drive_next = ramped;
          end
        end
        ST_DWELL: begin
          drive_next = 16'sd0;
          // Dwell runs to completion regardless of what the target does meanwhile.
          if (dwell_reg <= 20'd1) begin
            state_next    = (eff_target == 16'sd0) ? ST_IDLE : ST_RUN;
            last_dir_next = DIR_NONE;
            dwell_next    = 20'd0;
          end else begin
            dwell_next = dwell_reg - 20'd1;
          end
        end
        default: begin
          tick_next = 16'd0;
          if (fault_clr) begin
            state_next    = ST_IDLE;
            target_next   = 16'sd0;
            last_dir_next = DIR_NONE;
          end
        end
      endcase
    end

    eff_target_next = enable ? target_next : 16'sd0;
    at_target_next  = (drive_next == eff_target_next) && (state_next != ST_DWELL);
    cmd_ready_next  = (state_next != ST_FAULT);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg     <= ST_IDLE;
      drive_reg     <= 16'sd0;
      target_reg    <= 16'sd0;
      last_dir_reg  <= DIR_NONE;
      tick_reg      <= 16'd0;
      dwell_reg     <= 20'd0;
      cmd_ready_reg <= 1'b1;
      at_target_reg <= 1'b1;
    end else begin
      state_reg     <= state_next;
      drive_reg     <= drive_next;
      target_reg    <= target_next;
      last_dir_reg  <= last_dir_next;
      tick_reg      <= tick_next;
      dwell_reg     <= dwell_next;
      cmd_ready_reg <= cmd_ready_next;
      at_target_reg <= at_target_next;
    end
  end

  assign cmd_bus.cmd_ready = cmd_ready_reg;
  assign drive_cmd         = drive_reg;
  assign state             = state_reg;
  assign at_target         = at_target_reg;

endmodule
